// File: rtl/pipe_mon_pkg.sv
// Shared types for the pipeline run monitor: FSM state encoding
// and the default counter width / saturate value.
package pipe_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } mon_state_t;

    localparam int CNT_W_DEF = 32;
    localparam logic [CNT_W_DEF-1:0] CNT_SAT_DEF = '1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, reset (sync, active-low), clr, inc -> q (sticks at all-ones).
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] MAX = '1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != MAX)) begin
            q <= q + ONE;
        end
    end

endmodule

// File: rtl/pipeline_run_monitor.sv
// Run monitor: counts RUN cycles, stalls, flushes and longest stall burst;
// declares pass after STABLE_CYCLES all-match cycles, or fail on TIMEOUT.
// Ports: clk, reset (sync, active-low), start, element_flat, expect_flat,
// stall, flush -> cycle_cnt, stall_cnt, flush_cnt, stall_run_max,
// match_mask, busy, done, pass.
module pipeline_run_monitor
    import pipe_mon_pkg::*;
#(
    parameter int NUM_ELEM      = 3,
    parameter int DATA_W        = 64,
    parameter int CNT_W         = 32,
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT       = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [NUM_ELEM*DATA_W-1:0] element_flat,
    input  logic [NUM_ELEM*DATA_W-1:0] expect_flat,
    input  logic                       stall,
    input  logic                       flush,
    output logic [CNT_W-1:0]           cycle_cnt,
    output logic [CNT_W-1:0]           stall_cnt,
    output logic [CNT_W-1:0]           flush_cnt,
    output logic [CNT_W-1:0]           stall_run_max,
    output logic [NUM_ELEM-1:0]        match_mask,
    output logic                       busy,
    output logic                       done,
    output logic                       pass
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

    mon_state_t state_q;
    mon_state_t state_d;

    logic                run;
    logic [NUM_ELEM-1:0] eq;
    logic                all_match;
    logic [CNT_W-1:0]    stable_q;
    logic [CNT_W-1:0]    cur_run_q;
    logic [CNT_W-1:0]    cur_run_nxt;
    logic                stable_hit;
    logic                time_hit;

    assign run = (state_q == RUN);

    for (genvar i = 0; i < NUM_ELEM; i++) begin : g_cmp
        assign eq[i] = (element_flat[i*DATA_W +: DATA_W]
                        == expect_flat[i*DATA_W +: DATA_W]);
    end

    assign all_match = &eq;

    sat_counter #(.CNT_W(CNT_W)) u_cycle (
        .clk   (clk),
        .reset (reset),
        .clr   (start),
        .inc   (run),
        .q     (cycle_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall (
        .clk   (clk),
        .reset (reset),
        .clr   (start),
        .inc   (run & stall),
        .q     (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush (
        .clk   (clk),
        .reset (reset),
        .clr   (start),
        .inc   (run & flush),
        .q     (flush_cnt)
    );

    // Consecutive all-match cycles; any mismatch in RUN restarts it.
    sat_counter #(.CNT_W(CNT_W)) u_stable (
        .clk   (clk),
        .reset (reset),
        .clr   (start | (run & ~all_match)),
        .inc   (run & all_match),
        .q     (stable_q)
    );

    // Length of the stall burst in progress, before this cycle.
    sat_counter #(.CNT_W(CNT_W)) u_cur_run (
        .clk   (clk),
        .reset (reset),
        .clr   (start | (run & ~stall)),
        .inc   (run & stall),
        .q     (cur_run_q)
    );

    // Burst length including this cycle, clamped like every counter.
    assign cur_run_nxt = (cur_run_q == CNT_MAX) ? CNT_MAX
                                                : cur_run_q + ONE;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_run_max <= '0;
        end else if (start) begin
            stall_run_max <= '0;
        end else if (run && stall && (cur_run_nxt > stall_run_max)) begin
            stall_run_max <= cur_run_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            match_mask <= '0;
        end else if (start) begin
            match_mask <= '0;
        end else if (run) begin
            match_mask <= eq;
        end
    end

    // Hits are judged on the values the counters take at this edge.
    assign stable_hit = run & all_match & (stable_q == STB_LAST);
    assign time_hit   = run & (cycle_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Stable is checked ahead of timeout so a tie resolves to PASS.
    always_comb begin
        state_d = state_q;
        priority case (1'b1)
            start:      state_d = RUN;
            stable_hit: state_d = PASS;
            time_hit:   state_d = FAIL;
            default:    state_d = state_q;
        endcase
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == PASS) || (state_q == FAIL);
    assign pass = (state_q == PASS);

endmodule

// File: tb/tb_pipeline_run_monitor.sv
// Self-checking bench for pipeline_run_monitor: directed sequences,
// a stall/flush vector table and randomized runs against a reference model.
module tb_pipeline_run_monitor;

    localparam int NE = 3;
    localparam int DW = 64;
    localparam int CW = 32;
    localparam int SC = 4;
    localparam int TO = 20;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic            stall = 1'b0;
    logic            flush = 1'b0;
    logic [NE*DW-1:0] el = '0;
    logic [NE*DW-1:0] ex = '0;

    logic [CW-1:0] cyc_a, stc_a, flc_a, mx_a;
    logic [NE-1:0] mm_a;
    logic          busy_a, done_a, pass_a;

    logic [3:0]    cyc_b, stc_b, flc_b, mx_b;
    logic [NE-1:0] mm_b;
    logic          busy_b, done_b, pass_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipeline_run_monitor #(
        .NUM_ELEM(NE), .DATA_W(DW), .CNT_W(CW),
        .STABLE_CYCLES(SC), .TIMEOUT(TO)
    ) dut_a (
        .clk(clk), .reset(reset), .start(start),
        .element_flat(el), .expect_flat(ex),
        .stall(stall), .flush(flush),
        .cycle_cnt(cyc_a), .stall_cnt(stc_a), .flush_cnt(flc_a),
        .stall_run_max(mx_a), .match_mask(mm_a),
        .busy(busy_a), .done(done_a), .pass(pass_a)
    );

    pipeline_run_monitor #(
        .NUM_ELEM(NE), .DATA_W(DW), .CNT_W(4),
        .STABLE_CYCLES(SC), .TIMEOUT(15)
    ) dut_b (
        .clk(clk), .reset(reset), .start(start),
        .element_flat(el), .expect_flat(ex),
        .stall(stall), .flush(flush),
        .cycle_cnt(cyc_b), .stall_cnt(stc_b), .flush_cnt(flc_b),
        .stall_run_max(mx_b), .match_mask(mm_b),
        .busy(busy_b), .done(done_b), .pass(pass_b)
    );

    // Reference model: history of the current run kept as queues.
    bit            h_stall[$];
    bit            h_match[$];
    int            m_st  = 0;
    int            m_fl  = 0;
    int            m_max = 0;
    logic [NE-1:0] m_mask = '0;

    function automatic int trail(input bit q[$]);
        int n = 0;
        for (int k = q.size() - 1; k >= 0; k--) begin
            if (!q[k]) break;
            n++;
        end
        return n;
    endfunction

    function automatic int ones(input bit q[$]);
        int n = 0;
        foreach (q[k]) n += int'(q[k]);
        return n;
    endfunction

    always @(posedge clk) begin : model
        logic [NE-1:0] e;
        for (int i = 0; i < NE; i++)
            e[i] = (el[i*DW +: DW] == ex[i*DW +: DW]);
        if (!reset || start) begin
            m_st = (!reset) ? 0 : 1;
            h_stall.delete();
            h_match.delete();
            m_fl = 0;
            m_max = 0;
            m_mask = '0;
        end else if (m_st == 1) begin
            h_stall.push_back(stall);
            h_match.push_back(&e);
            if (flush) m_fl++;
            m_mask = e;
            if (stall && trail(h_stall) > m_max) m_max = trail(h_stall);
            if (trail(h_match) >= SC) m_st = 2;
            else if (h_stall.size() == TO) m_st = 3;
        end
    end

    function automatic logic [159:0] model_exp();
        return 160'({32'(h_stall.size()), 32'(ones(h_stall)),
                     32'(m_fl), 32'(m_max), m_mask,
                     m_st == 1, m_st >= 2, m_st == 2});
    endfunction

    function automatic logic [159:0] dut_act();
        return 160'({cyc_a, stc_a, flc_a, mx_a, mm_a,
                     busy_a, done_a, pass_a});
    endfunction

    task automatic chk(input string nm, input logic [159:0] act,
                       input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("model", dut_act(), model_exp());
    endtask

    task automatic set_elems(input logic [NE-1:0] mism);
        logic [DW-1:0] r;
        for (int i = 0; i < NE; i++) begin
            r = {$urandom, $urandom};
            ex[i*DW +: DW] = r;
            if (mism[i]) r = r ^ ({$urandom, $urandom} | 64'h1);
            el[i*DW +: DW] = r;
        end
    endtask

    typedef struct {
        logic        stl;
        logic        fl;
        logic [31:0] cyc;
        logic [31:0] sc;
        logic [31:0] fc;
        logic [31:0] mx;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int pct;
        logic [NE-1:0] mm;

        tbl[0] = '{1'b1, 1'b0, 32'd1, 32'd1, 32'd0, 32'd1};
        tbl[1] = '{1'b1, 1'b1, 32'd2, 32'd2, 32'd1, 32'd2};
        tbl[2] = '{1'b0, 1'b0, 32'd3, 32'd2, 32'd1, 32'd2};
        tbl[3] = '{1'b1, 1'b0, 32'd4, 32'd3, 32'd1, 32'd2};
        tbl[4] = '{1'b1, 1'b0, 32'd5, 32'd4, 32'd1, 32'd2};
        tbl[5] = '{1'b1, 1'b1, 32'd6, 32'd5, 32'd2, 32'd3};
        tbl[6] = '{1'b0, 1'b0, 32'd7, 32'd5, 32'd2, 32'd3};

        // Reset state, then reset in the middle of a run.
        set_elems(3'b010);
        tick();
        tick();
        chk("reset_state", dut_act(), 160'd0);
        reset = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            stall = 1'($urandom_range(0, 1));
            set_elems(3'b010);
            tick();
        end
        chk("t1_busy", 160'(busy_a), 160'(1'b1));
        chk("t1_cycles", 160'(cyc_a), 160'(32'd10));
        reset = 1'b0;
        tick();
        chk("t1_reset_all", dut_act(), 160'd0);
        reset = 1'b1;
        stall = 1'b0;
        tick();
        chk("t1_idle_busy", 160'(busy_a), 160'(1'b0));

        // Match from cycle 3 onward.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            set_elems(k < 3 ? 3'b010 : 3'b000);
            tick();
            if (k == 2) chk("t2_mask_c2", 160'(mm_a), 160'(3'b101));
            if (k == 3) chk("t2_mask_c3", 160'(mm_a), 160'(3'b111));
            if (k == 5) chk("t2_pass_c5", 160'(pass_a), 160'(1'b0));
        end
        chk("t2_pass", 160'({pass_a, done_a}), 160'(2'b11));
        chk("t2_cycles", 160'(cyc_a), 160'(32'd6));
        set_elems(3'b111);
        tick();
        chk("t2_freeze", 160'({cyc_a, mm_a, pass_a}),
            160'({32'd6, 3'b111, 1'b1}));

        // Element 1 mismatches every third cycle: timeout.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= TO; k++) begin
            set_elems((k % 3 == 0) ? 3'b010 : 3'b000);
            tick();
            if (k == TO - 1) chk("t3_busy_c19", 160'(busy_a), 160'(1'b1));
        end
        chk("t3_fail", 160'({done_a, pass_a, busy_a}), 160'(3'b100));
        chk("t3_cycles", 160'(cyc_a), 160'(32'd20));

        // Stall/flush table.
        set_elems(3'b111);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            stall = tbl[k].stl;
            flush = tbl[k].fl;
            tick();
            chk($sformatf("t4_row%0d", k),
                160'({cyc_a, stc_a, flc_a, mx_a}),
                160'({tbl[k].cyc, tbl[k].sc, tbl[k].fc, tbl[k].mx}));
        end
        stall = 1'b0;
        flush = 1'b0;

        // Stable reached on the timeout cycle itself.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= TO; k++) begin
            set_elems(k < 17 ? 3'b001 : 3'b000);
            tick();
            if (k == TO - 1) chk("t5_pass_c19", 160'(pass_a), 160'(1'b0));
        end
        chk("t5_pass", 160'({pass_a, done_a}), 160'(2'b11));
        chk("t5_cycles", 160'(cyc_a), 160'(32'd20));

        // Narrow counters: stall held high until timeout, then restart.
        set_elems(3'b100);
        start = 1'b1;
        tick();
        start = 1'b0;
        stall = 1'b1;
        for (int k = 1; k <= 15; k++) tick();
        chk("t6_sat", 160'({stc_b, mx_b, cyc_b}),
            160'({4'd15, 4'd15, 4'd15}));
        chk("t6_fail", 160'({done_b, pass_b}), 160'(2'b10));
        for (int k = 0; k < 3; k++) tick();
        chk("t6_hold", 160'({stc_b, cyc_b}), 160'({4'd15, 4'd15}));
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_restart", 160'({cyc_b, stc_b, flc_b, mx_b, mm_b, busy_b}),
            160'({4'd0, 4'd0, 4'd0, 4'd0, 3'b000, 1'b1}));
        tick();
        chk("t6_count", 160'(stc_b), 160'(4'd1));
        stall = 1'b0;

        // Randomized runs against the model.
        pct = 0;
        for (int c = 0; c < 800; c++) begin
            if (c % 40 == 0) begin
                case ($urandom_range(0, 3))
                    0: pct = 0;
                    1: pct = 5;
                    2: pct = 30;
                    default: pct = 100;
                endcase
            end
            reset = ($urandom_range(0, 299) != 0);
            start = (m_st == 1) ? ($urandom_range(0, 99) == 0)
                                : ($urandom_range(0, 3) == 0);
            stall = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < NE; i++)
                mm[i] = ($urandom_range(0, 99) < pct);
            set_elems(mm);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
